// File: rtl/load_commutation_fsm_if.sv
// Control/gate-driver bundle for load_commutation_fsm: load request, current sign, short detect in; gate commands out.
interface load_commutation_fsm_if;
    logic       start;
    logic [1:0] DesiredLoad;
    logic       CurrentSign;
    logic       Short;
    logic [5:0] Sout;

    modport master (output start, DesiredLoad, CurrentSign, Short, input Sout);
    modport slave  (input start, DesiredLoad, CurrentSign, Short, output Sout);
endinterface

// File: rtl/load_commutation_fsm.sv
// Steers one source onto load A/B/C using current-direction-aware 4-step commutation, with sticky short fault.
// Optional macro SHORT_COMB_KILL_EN: also gates Sout combinationally with ~Short.
module load_commutation_fsm #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    load_commutation_fsm_if.slave  bus
);

    localparam int unsigned CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned SOUT_W = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ON    = 3'd1,
        COMM  = 3'd2,
        FAULT = 3'd3
    } state_t;

    state_t              state;
    logic [1:0]          cur_load;
    logic [1:0]          tgt_load;
    logic                sign_q;
    logic [1:0]          step;
    logic [CNT_W-1:0]    cnt;
    logic [SOUT_W-1:0]   sout_q;

    // Position a 2-bit pair code onto the gate bus for a given load.
    function automatic logic [SOUT_W-1:0] place(input logic [1:0] load, input logic [1:0] code);
        case (load)
            2'd1:    place = {code, 4'b0000};
            2'd2:    place = {2'b00, code, 2'b00};
            2'd3:    place = {4'b0000, code};
            default: place = '0;
        endcase
    endfunction

    // Gate pattern of commutation step s (0..3) from load x to load y; positive current keeps hi switches.
    function automatic logic [SOUT_W-1:0] step_out(input logic [1:0] x, input logic [1:0] y,
                                                   input logic sgn, input logic [1:0] s);
        logic [1:0] half;
        half = sgn ? 2'b10 : 2'b01;
        case (s)
            2'd0:    step_out = place(x, half);
            2'd1:    step_out = place(x, half) | place(y, half);
            2'd2:    step_out = place(y, half);
            default: step_out = place(y, 2'b11);
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_load <= 2'd0;
            tgt_load <= 2'd0;
            sign_q   <= 1'b0;
            step     <= 2'd0;
            cnt      <= '0;
            sout_q   <= '0;
        end else if (bus.Short) begin
            state  <= FAULT;
            sout_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sout_q <= '0;
                    if (bus.start && (bus.DesiredLoad != 2'd0)) begin
                        state    <= ON;
                        cur_load <= bus.DesiredLoad;
                        sout_q   <= place(bus.DesiredLoad, 2'b11);
                    end
                end
                ON: begin
                    if (!bus.start || (bus.DesiredLoad == 2'd0)) begin
                        state  <= IDLE;
                        sout_q <= '0;
                    end else if (bus.DesiredLoad != cur_load) begin
                        state    <= COMM;
                        tgt_load <= bus.DesiredLoad;
                        sign_q   <= bus.CurrentSign;
                        step     <= 2'd0;
                        cnt      <= '0;
                        sout_q   <= step_out(cur_load, bus.DesiredLoad, bus.CurrentSign, 2'd0);
                    end
                end
                COMM: begin
                    // Inputs other than Short are ignored until the incoming load is fully on.
                    if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (step == 2'd3) begin
                            state    <= ON;
                            cur_load <= tgt_load;
                        end else begin
                            step   <= 2'(step + 2'd1);
                            sout_q <= step_out(cur_load, tgt_load, sign_q, 2'(step + 2'd1));
                        end
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
                FAULT: begin
                    sout_q <= '0;
                end
                default: begin
                    state  <= FAULT;
                    sout_q <= '0;
                end
            endcase
        end
    end

`ifdef SHORT_COMB_KILL_EN
    assign bus.Sout = sout_q & {SOUT_W{~bus.Short}};
`else
    assign bus.Sout = sout_q;
`endif

endmodule

// File: tb/tb_load_commutation_fsm.sv
// Scoreboard bench for load_commutation_fsm: directed steps push expected Sout, a monitor pops and compares.
module tb_load_commutation_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;

    load_commutation_fsm_if bus ();

    load_commutation_fsm #(.STEP_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       chk;
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    // Monitor: one scoreboard entry per clock, compared just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                if (e.chk) begin
                    tests++;
                    if (bus.Sout !== e.exp) begin
                        failed++;
                        $display("FAIL %s: Sout=%b expected %b", e.name, bus.Sout, e.exp);
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs on the falling edge and queue the Sout expected after the next rising edge.
    task automatic step(input logic r, input logic s, input logic [1:0] dl, input logic cs,
                        input logic sh, input logic [5:0] e, input string n);
        exp_t x;
        @(negedge clk);
        rst             = r;
        bus.start       = s;
        bus.DesiredLoad = dl;
        bus.CurrentSign = cs;
        bus.Short       = sh;
        x.chk  = 1'b1;
        x.exp  = e;
        x.name = n;
        q.push_back(x);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.DesiredLoad = 2'b00;
        bus.CurrentSign = 1'b0;
        bus.Short       = 1'b0;

        step(1, 0, 2'b00, 0, 0, 6'b000000, "reset0");
        step(1, 0, 2'b00, 0, 0, 6'b000000, "reset1");
        step(0, 0, 2'b00, 0, 0, 6'b000000, "idle_after_reset");

        for (int i = 0; i < 6; i++) step(0, 0, 2'b01, 0, 0, 6'b000000, "start_low_off");
        step(0, 1, 2'b01, 0, 0, 6'b110000, "on_a");
        step(0, 1, 2'b01, 0, 0, 6'b110000, "hold_a0");
        step(0, 1, 2'b01, 0, 0, 6'b110000, "hold_a1");

        // A -> B, positive current
        step(0, 1, 2'b10, 1, 0, 6'b100000, "ab_pos_s1");
        step(0, 1, 2'b10, 1, 0, 6'b101000, "ab_pos_s2");
        step(0, 1, 2'b10, 1, 0, 6'b001000, "ab_pos_s3");
        step(0, 1, 2'b10, 1, 0, 6'b001100, "ab_pos_s4");
        step(0, 1, 2'b10, 1, 0, 6'b001100, "hold_b0");
        step(0, 1, 2'b10, 1, 0, 6'b001100, "hold_b1");

        // B -> A, negative current; sign flip mid-commutation is ignored
        step(0, 1, 2'b01, 0, 0, 6'b000100, "ba_neg_s1");
        step(0, 1, 2'b01, 1, 0, 6'b010100, "ba_neg_s2");
        step(0, 1, 2'b01, 1, 0, 6'b010000, "ba_neg_s3");
        step(0, 1, 2'b01, 0, 0, 6'b110000, "ba_neg_s4");
        step(0, 1, 2'b01, 0, 0, 6'b110000, "hold_a2");

        // A -> C with request withdrawn mid-commutation: completes, then re-evaluates to IDLE
        step(0, 1, 2'b11, 1, 0, 6'b100000, "ac_s1");
        step(0, 0, 2'b10, 0, 0, 6'b100010, "ac_s2_ignore");
        step(0, 0, 2'b10, 0, 0, 6'b000010, "ac_s3_ignore");
        step(0, 0, 2'b10, 0, 0, 6'b000011, "ac_s4");
        step(0, 0, 2'b10, 0, 0, 6'b000011, "ac_reach_on_c");
        step(0, 0, 2'b10, 0, 0, 6'b000000, "ac_then_idle");

        // start toggling from ON_A
        step(0, 1, 2'b01, 0, 0, 6'b110000, "restart_a");
        step(0, 0, 2'b01, 0, 0, 6'b000000, "start_low_a");
        step(0, 1, 2'b01, 0, 0, 6'b110000, "start_high_a");

        // Short from ON_A is sticky
        step(0, 1, 2'b01, 0, 1, 6'b000000, "short_kill");
        step(0, 1, 2'b11, 0, 0, 6'b000000, "fault_sticky0");
        step(0, 1, 2'b11, 0, 0, 6'b000000, "fault_sticky1");
        step(0, 1, 2'b11, 1, 0, 6'b000000, "fault_sticky2");
        step(1, 1, 2'b11, 0, 0, 6'b000000, "fault_rst");
        step(0, 1, 2'b11, 0, 0, 6'b000011, "after_rst_on_c");

        // Short during commutation C -> A
        step(0, 1, 2'b01, 1, 0, 6'b000010, "ca_pos_s1");
        step(0, 1, 2'b01, 1, 1, 6'b000000, "short_in_comm");
        step(0, 1, 2'b01, 1, 0, 6'b000000, "fault_after_comm");
        step(1, 0, 2'b00, 0, 0, 6'b000000, "final_rst");
        step(0, 0, 2'b00, 0, 0, 6'b000000, "final_idle");

        repeat (4) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/load_commutation_fsm.md
Name: load_commutation_fsm

Overview:
- Sequencer that steers one source onto one of three loads (A, B, C) through bidirectional switch pairs.
- Uses current-direction-aware 4-step commutation so a load change never shorts two loads or opens the current path.
- Sits between the control/load-select logic and the gate drivers.
- A short-circuit input forces all switches off and latches a fault until reset.

Parameters:
- STEP_CYCLES, 1, clock cycles each commutation step is held (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  enable; while low, all switches stay off.
- DesiredLoad  input  2  requested load: 00 none, 01 A, 10 B, 11 C.
- CurrentSign  input  1  load current direction: 1 positive, 0 negative.
- Short  input  1  short-circuit detect, active high.
- Sout  output  6  gate commands, registered. [5:4] load A, [3:2] load B, [1:0] load C. Within a pair, hi bit = positive-current switch, lo bit = negative-current switch.

Behaviour:
- Reset: asynchronous, active-high. Sout=000000, state IDLE, fault cleared, step counter 0.
- All inputs are sampled on the rising clk edge. Sout is registered and reflects the state entered at that edge, giving 1-cycle latency.
- Pair codes: full-on = 11, off = 00. SAA=110000, SBB=001100, SCC=000011.
- State IDLE (Sout=0):
  - Go to ON_X when start=1 and DesiredLoad!=00; target pair driven 11 directly, no commutation.
- State ON_X (X in A/B/C, pair X=11):
  - start=0 or DesiredLoad=00: go to IDLE, Sout=0 next cycle.
  - DesiredLoad=Y with Y!=X: enter COMMUTATE. CurrentSign is latched at entry.
  - DesiredLoad=X: stay.
- COMMUTATE, 4 steps, each held STEP_CYCLES cycles. X = outgoing, Y = incoming.
  - Latched sign=1:
    - step1: X.lo off (X=10)
    - step2: Y.hi on (X=10, Y=10)
    - step3: X.hi off (Y=10)
    - step4: Y.lo on (Y=11), then go to ON_Y.
  - Latched sign=0:
    - step1: X.hi off (X=01)
    - step2: Y.lo on
    - step3: X.lo off
    - step4: Y.hi on, then go to ON_Y.
  - DesiredLoad and start changes during COMMUTATE are ignored until ON_Y is reached, then re-evaluated.
  - CurrentSign changes mid-commutation are ignored.
- FAULT:
  - Short=1 at any clock edge, in any state, takes priority over all other inputs: go to FAULT, Sout=000000 next cycle.
  - FAULT is sticky. Only rst exits it; start, DesiredLoad and Short deassertion have no effect.
- Invariant: at most one full pair is on outside COMMUTATE. No pair is ever 00 on both X and Y simultaneously while in COMMUTATE.
- Illegal or unused state encodings go to FAULT.

Optional Feature:
- SHORT_COMB_KILL_EN
  - Defined: Sout is additionally ANDed combinationally with ~Short, so gates drop in the same cycle Short rises. Registered FAULT latching is unchanged.
  - Undefined: Sout is purely registered, and turn-off occurs one clock after Short is sampled.

Test Plan:
- rst=1 for 2 cycles, then release with DesiredLoad=00, start=0 -> Sout=000000.
- DesiredLoad=01, start=0 for 6 cycles -> Sout stays 000000. Then start=1 -> Sout=110000 one cycle later and held.
- From SAA, CurrentSign=1, DesiredLoad=10, STEP_CYCLES=1 -> Sout sequence 100000, 101000, 001000, 001100, then holds 001100.
- From SBB, CurrentSign=0, DesiredLoad=01 -> Sout sequence 000100, 010100, 010000, 110000, then holds 110000.
- From SAA, Short=1 for one cycle, then Short=0 and DesiredLoad=11 -> Sout=000000 and stays 000000. After rst pulse with start=1 -> Sout=000011.
- From ON_A, start=0 -> Sout=000000 next cycle. start=1 again -> Sout=110000.
